upg_mem_scheduler: RTL
======================

// Module: upg_mem_scheduler
// PURPOSE
// - Owns the IM/DM write ports; shares them between the CPU and the UART program uploader.
// - IDLE: CPU owns the DM write port and runs normally.
// - After a start request: holds the CPU in reset, packs UART bytes into 32-bit words, writes IM then DM.
// - Returns port ownership to the CPU when the image ends.
// PARAMETERS
// - IM_ADDR_W    14     IM word-address width
// - DM_ADDR_W    14     DM word-address width
// - IM_WORDS     16384  words written to IM before switching to DM (<= 2**IM_ADDR_W)
// - DM_WORDS     16384  words written to DM before DONE (<= 2**DM_ADDR_W)
// - IDLE_TIMEOUT 100000 cycles with no byte during a load that end it; >= 2
// PORTS
// - iUpgClock        in  1          sole clock, rising edge
// - iFpgaReset       in  1          synchronous, active-high reset
// - iStartReceiveCoe in  1          start-upload request, level; sampled in IDLE only
// - iRxByteValid     in  1          one-cycle strobe: iRxByte valid
// - iRxByte          in  8          received UART byte
// - iCpuDoMemWrite   in  1          CPU DM write enable
// - iCpuDmAddress    in  DM_ADDR_W  CPU DM word address
// - iCpuDataToStore  in  32         CPU DM write data
// - oCpuReset        out 1          CPU reset, registered
// - oLoading         out 1          1 in LOAD_IM/LOAD_DM
// - oImWriteEnable   out 1          IM write strobe
// - oImAddress       out IM_ADDR_W  IM write word address
// - oImWriteData     out 32         IM write data
// - oDmWriteEnable   out 1          DM write strobe
// - oDmAddress       out DM_ADDR_W  DM word address
// - oDmWriteData     out 32         DM write data
// - oLoadDone        out 1          one-cycle pulse on a clean load end
// - oLoadError       out 1          sticky: load ended mid-word
// - oChecksum        out 32         see CONFIGURATION
// BEHAVIOUR
// - Reset: state=IDLE; oCpuReset=1 during the reset cycle, 0 on the first cycle after it.
//   All other outputs, byte counter, word counters and timeout counter reset to 0.
// - States: IDLE, LOAD_IM, LOAD_DM, DONE, ERROR.
// - IDLE: oDmWriteEnable/oDmAddress/oDmWriteData are combinational pass-throughs of the CPU inputs.
//   IM write is idle. iRxByteValid is ignored.
// - IDLE -> LOAD_IM when iStartReceiveCoe=1. On that edge:
//   oCpuReset<=1; all counters and the checksum clear; oLoadError clears.
// - LOAD_*: byte packing is little-endian; byte k goes to bits [8k+7:8k], k=0..3.
// - LOAD_*: the 4th byte produces a write strobe on the next cycle.
//   That write has the current word address and the packed word; the word address then +1.
// - LOAD_IM -> LOAD_DM on the write of word IM_WORDS-1; the DM address restarts at 0.
// - LOAD_DM -> DONE on the write of word DM_WORDS-1.
// - LOAD_*: CPU DM writes are dropped, never queued.
// - Timeout: counter clears on each iRxByteValid and increments otherwise; expiry at IDLE_TIMEOUT.
// - Timeout with byte counter=0 -> DONE; the short image is accepted.
// - Timeout with byte counter!=0 -> ERROR; oLoadError<=1; the partial word is discarded, never written.
// - A byte arriving on the expiry cycle wins: it is packed and the timeout counter clears.
// - DONE: lasts one cycle; oLoadDone=1; oCpuReset held 1; then IDLE with oCpuReset<=0.
// - ERROR: oCpuReset held 1 until iStartReceiveCoe=1, which restarts LOAD_IM exactly as from IDLE.
// - iStartReceiveCoe while in LOAD_*/DONE: ignored; a fresh image needs the level again in IDLE.
// - iFpgaReset during a load: the load is abandoned; IDLE after reset; memory already written keeps its contents.
// CONFIGURATION
// - UPG_CHECKSUM_EN defined:
//   oChecksum = mod-2^32 sum of every word written while loading; updates on each write strobe.
//   It clears on entry to LOAD_IM, then holds its value after DONE/ERROR.
// - UPG_CHECKSUM_EN undefined: oChecksum is constant 0 and no adder is synthesised.
// TESTING
// - Reset, then CPU write addr 5 data 0xDEADBEEF in IDLE -> oDmWriteEnable=1, oDmAddress=5, oDmWriteData=0xDEADBEEF, same cycle.
// - IM_WORDS=2, DM_WORDS=1, start, bytes 01 02 03 04 05 06 07 08 09 0A 0B 0C:
//   -> IM[0]=0x04030201, IM[1]=0x08070605, DM[0]=0x0C0B0A09; oLoadDone 1 cycle; oCpuReset falls the cycle after.
// - IDLE_TIMEOUT=16, start, 4 bytes, silence -> one IM write, then DONE after 16 idle cycles; oLoadError=0.
// - IDLE_TIMEOUT=16, start, 6 bytes, silence -> one IM write only; ERROR; oLoadError=1; oCpuReset stays 1 until a new start.
// - Reset asserted after 3 bytes of word 0 -> IDLE, no IM write, oCpuReset=0 the cycle after reset.
//   A CPU write during LOAD_DM -> no DM strobe.
// - UPG_CHECKSUM_EN defined, image 0x00000001, 0xFFFFFFFF -> oChecksum=0x00000000.
//   Undefined -> oChecksum=0 throughout.

Source files
------------

// File: rtl/upg_mem_scheduler.sv
// upg_mem_scheduler: shares IM/DM write ports between the CPU and the UART program uploader.
// Optional running checksum of loaded words when UPG_CHECKSUM_EN is defined.
module upg_mem_scheduler #(
  parameter int IM_ADDR_W    = 14,
  parameter int DM_ADDR_W    = 14,
  parameter int IM_WORDS     = 16384,
  parameter int DM_WORDS     = 16384,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic                 iUpgClock,
  input  logic                 iFpgaReset,
  input  logic                 iStartReceiveCoe,
  input  logic                 iRxByteValid,
  input  logic [7:0]           iRxByte,
  input  logic                 iCpuDoMemWrite,
  input  logic [DM_ADDR_W-1:0] iCpuDmAddress,
  input  logic [31:0]          iCpuDataToStore,
  output logic                 oCpuReset,
  output logic                 oLoading,
  output logic                 oImWriteEnable,
  output logic [IM_ADDR_W-1:0] oImAddress,
  output logic [31:0]          oImWriteData,
  output logic                 oDmWriteEnable,
  output logic [DM_ADDR_W-1:0] oDmAddress,
  output logic [31:0]          oDmWriteData,
  output logic                 oLoadDone,
  output logic                 oLoadError,
  output logic [31:0]          oChecksum
);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IM_ADDR_W-1:0] IM_LAST = IM_ADDR_W'(IM_WORDS - 1);
  localparam logic [DM_ADDR_W-1:0] DM_LAST = DM_ADDR_W'(DM_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, LOAD_IM, LOAD_DM, DONE, ERROR} state_t;
  state_t state, next;
  logic [1:0] byte_cnt;
  logic [23:0] acc;
  logic [31:0] wr_data;
  logic wr_pend, cpu_rst, load_err, loading, wr, expire, start;
  logic [IM_ADDR_W-1:0] im_addr;
  logic [DM_ADDR_W-1:0] dm_addr;
  logic [TW-1:0] to_cnt;
  assign loading = state == LOAD_IM || state == LOAD_DM;
  assign wr = loading && wr_pend;
  assign expire = loading && !iRxByteValid && to_cnt == TO_LAST;
  assign start = (state == IDLE || state == ERROR) && iStartReceiveCoe;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = iStartReceiveCoe ? LOAD_IM : IDLE;
      LOAD_IM: next = (wr && im_addr == IM_LAST) ? LOAD_DM : expire ? (byte_cnt == 2'd0 ? DONE : ERROR) : LOAD_IM;
      LOAD_DM: next = (wr && dm_addr == DM_LAST) ? DONE : expire ? (byte_cnt == 2'd0 ? DONE : ERROR) : LOAD_DM;
      DONE:    next = IDLE;
      ERROR:   next = iStartReceiveCoe ? LOAD_IM : ERROR;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge iUpgClock) begin
    if (iFpgaReset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      acc      <= '0;
      wr_data  <= '0;
      wr_pend  <= 1'b0;
      im_addr  <= '0;
      dm_addr  <= '0;
      to_cnt   <= '0;
      cpu_rst  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state   <= next;
      cpu_rst <= next != IDLE;
      wr_pend <= loading && iRxByteValid && byte_cnt == 2'd3;
      if (start) begin
        byte_cnt <= '0;
        acc      <= '0;
        im_addr  <= '0;
        dm_addr  <= '0;
        to_cnt   <= '0;
        load_err <= 1'b0;
      end else if (loading) begin
        to_cnt <= iRxByteValid ? '0 : to_cnt + 1'b1;
        if (iRxByteValid) begin
          byte_cnt <= byte_cnt + 1'b1;
          acc      <= {iRxByte, acc[23:8]};
          if (byte_cnt == 2'd3) wr_data <= {iRxByte, acc};
        end
        if (wr && state == LOAD_IM) im_addr <= im_addr + 1'b1;
        if (wr && state == LOAD_DM) dm_addr <= dm_addr + 1'b1;
        if (next == ERROR) load_err <= 1'b1;
      end
    end
  end
`ifdef UPG_CHECKSUM_EN
  logic [31:0] chk;
  always_ff @(posedge iUpgClock) begin
    if (iFpgaReset) chk <= '0;
    else if (start) chk <= '0;
    else if (wr) chk <= chk + wr_data;
  end
  assign oChecksum = chk;
`else
  assign oChecksum = '0;
`endif
  // CPU reset is forced while the board reset is asserted, then follows the registered state
  assign oCpuReset      = cpu_rst | iFpgaReset;
  assign oLoading       = loading;
  assign oImWriteEnable = wr && state == LOAD_IM;
  assign oImAddress     = im_addr;
  assign oImWriteData   = wr_data;
  assign oDmWriteEnable = state == IDLE ? iCpuDoMemWrite : wr && state == LOAD_DM;
  assign oDmAddress     = state == IDLE ? iCpuDmAddress : dm_addr;
  assign oDmWriteData   = state == IDLE ? iCpuDataToStore : wr_data;
  assign oLoadDone      = state == DONE;
  assign oLoadError     = load_err;
endmodule
